instr_fetch_sequencer: RTL and testbench
========================================

// Module: instr_fetch_sequencer
// PURPOSE
//  Multicycle control FSM for the 16-bit datapath's instruction/data register stage.
//  Fetches each 32-bit instruction as two 16-bit memory reads (low half -> IRWr0, high half -> IRWr1).
//  Decodes the opcode, sequences the EXE/MEM/WB steps and drives MemWrite, MemtoReg, RegDst, RegWrite.
//  Owns the PC and the single memory port shared by instruction fetch and load/store.
// PARAMETERS
//  AW        16      memory/PC address width (16-bit word addressed)
//  RESET_PC  16'h0   PC value loaded on reset
// PORTS
//  Fclk       in   1   clock, all state updates on rising edge
//  Rst_n      in   1   asynchronous active-low reset
//  run        in   1   1 = fetch/execute continuously; sampled only at instruction boundary (IDLE)
//  instr      in   32  instruction register contents {hi,lo}; opcode = instr[31:26]
//  alu_addr   in   AW  effective address from ALU, valid in EXE/MEM
//  mem_ack    in   1   memory transfer complete this cycle (read data valid on data_in)
//  mem_req    out  1   memory access request
//  mem_we     out  1   1 = write access (equals MemWrite)
//  mem_addr   out  AW  memory address: pc (F_LO), pc+1 (F_HI), alu_addr (MEM)
//  pc         out  AW  current program counter
//  IRWr0      out  1   load low instruction half
//  IRWr1      out  1   load high instruction half
//  MemWrite   out  1   store enable / io mux select to WriteData
//  MemtoReg   out  1   1 = write-back data from memory data register, 0 = ALU
//  RegDst     out  1   1 = dest reg instr[15:11], 0 = instr[20:16]
//  RegWrite   out  1   register file write strobe
//  halted     out  1   sticky: HALT reached
//  illegal    out  1   sticky: unsupported opcode decoded
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, pc=RESET_PC, all other outputs 0. A mid-access reset drops mem_req at once.
//  States: IDLE, F_LO, F_HI, DEC, EXE, MEM, WB, HALT.
//  IDLE: run=1 -> F_LO, else stay.
//  F_LO: mem_req=1, mem_addr=pc, mem_we=0; on mem_ack: IRWr0=1 that cycle only -> F_HI.
//  F_HI: mem_req=1, mem_addr=pc+1; on mem_ack: IRWr1=1 that cycle only, pc<=pc+2 (mod 2^AW) -> DEC.
//  DEC: decode instr[31:26]:
//   6'h00 R-type -> EXE; 6'h08 ADDI -> EXE; 6'h23 LW -> EXE; 6'h2B SW -> EXE.
//   6'h3F -> HALT.
//   Any other opcode -> illegal<=1, HALT.
//  EXE: one cycle (ALU result settles). R/ADDI -> WB; LW/SW -> MEM.
//  MEM: mem_req=1, mem_addr=alu_addr, mem_we=MemWrite=(SW). On mem_ack: LW -> WB; SW -> IDLE/F_LO.
//  WB: RegWrite=1 for exactly one cycle.
//   MemtoReg=1 for LW only. RegDst=1 for R-type only; 0 for ADDI/LW.
//   Next state: F_LO if run=1, else IDLE.
//  MemtoReg/RegDst hold their decoded value from DEC through WB; 0 otherwise.
//  Handshake: mem_req, mem_addr and mem_we are stable while waiting; mem_ack when mem_req=0 is ignored.
//   mem_req drops the cycle after the ack edge. Ack may arrive in the same cycle as req (zero wait).
//  Latency with zero-wait memory, F_LO to next F_LO: R/ADDI 5 cycles, SW 5, LW 6. Each wait cycle adds 1.
//  HALT: absorbing until reset; no mem_req, no strobes; halted=1.
//  run=0 mid-instruction: the current instruction completes, then the FSM parks in IDLE.
//  IRWr0, IRWr1, RegWrite and MemWrite are never asserted together with each other.
//   Exception: MemWrite is held during MEM until ack.
// TESTING
//  1. Reset RESET_PC=0, run=1, zero-wait mem, R-type at 0/1 -> IRWr0@cyc1, IRWr1@cyc2, RegWrite+RegDst=1@cyc5, pc=2.
//  2. LW (op 23), alu_addr=16'h0040, 3-cycle ack delay in MEM -> mem_addr=0040 held 3 cycles, WB MemtoReg=1, RegDst=0.
//  3. SW (op 2B) -> MEM with mem_we=MemWrite=1 until ack, no RegWrite, back to F_LO.
//  4. Opcode 6'h3F -> HALT, halted=1; opcode 6'h15 -> illegal=1, halted=1, no further mem_req.
//  5. pc=16'hFFFE fetch -> F_HI addr FFFF, pc wraps to 0000.
//  6. Rst_n low during F_HI wait -> mem_req=0 same cycle, pc=RESET_PC; run=0 mid-LW -> LW completes, then IDLE.

Source files
------------

// File: rtl/instr_fetch_sequencer_if.sv
// instr_fetch_sequencer_if: shared memory port between the fetch sequencer and memory
interface instr_fetch_sequencer_if #(parameter int AW = 16);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    modport master(output mem_req, output mem_we, output mem_addr, input mem_ack);
    modport slave(input mem_req, input mem_we, input mem_addr, output mem_ack);
endinterface

// File: rtl/instr_fetch_sequencer.sv
// instr_fetch_sequencer: multicycle fetch/decode/execute control FSM owning the PC and memory port
module instr_fetch_sequencer #(
    parameter int            AW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic                    Fclk,
    input  logic                    Rst_n,
    input  logic                    run,
    input  logic [31:0]             instr,
    input  logic [AW-1:0]           alu_addr,
    instr_fetch_sequencer_if.master bus,
    output logic [AW-1:0]           pc,
    output logic                    IRWr0,
    output logic                    IRWr1,
    output logic                    MemWrite,
    output logic                    MemtoReg,
    output logic                    RegDst,
    output logic                    RegWrite,
    output logic                    halted,
    output logic                    illegal
);
    typedef enum logic [2:0] {IDLE, F_LO, F_HI, DEC, EXE, MEM, WB, HALT} state_t;
    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_HALT = 6'h3F;
    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [5:0]    op_q, op_d;
    logic          illegal_q, illegal_d;
    logic [5:0]    op;
    logic          in_flow;
    logic          unused_instr;
    assign unused_instr = ^instr[25:0];
    assign pc = pc_q;
    // state, PC, latched opcode and sticky illegal flag
    always_ff @(posedge Fclk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
        end
    end
    // next state and control strobes; decode is visible in DEC before the opcode is latched
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        op_d         = op_q;
        illegal_d    = illegal_q;
        op           = (state_q == DEC) ? instr[31:26] : op_q;
        in_flow      = state_q inside {DEC, EXE, MEM, WB};
        bus.mem_req  = 1'b0;
        bus.mem_addr = pc_q;
        IRWr0        = 1'b0;
        IRWr1        = 1'b0;
        RegWrite     = 1'b0;
        MemWrite     = (state_q == MEM) && (op_q == OP_SW);
        bus.mem_we   = MemWrite;
        MemtoReg     = in_flow && (op == OP_LW);
        RegDst       = in_flow && (op == OP_R);
        halted       = (state_q == HALT);
        illegal      = illegal_q;
        case (state_q)
            IDLE: state_d = run ? F_LO : IDLE;
            F_LO: begin
                bus.mem_req = 1'b1;
                IRWr0       = bus.mem_ack;
                state_d     = bus.mem_ack ? F_HI : F_LO;
            end
            F_HI: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = pc_q + AW'(1);
                IRWr1        = bus.mem_ack;
                pc_d         = bus.mem_ack ? pc_q + AW'(2) : pc_q;
                state_d      = bus.mem_ack ? DEC : F_HI;
            end
            DEC: begin
                op_d      = instr[31:26];
                state_d   = (op_d inside {OP_R, OP_ADDI, OP_LW, OP_SW}) ? EXE : HALT;
                illegal_d = illegal_q | !(op_d inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_HALT});
            end
            EXE: state_d = (op_q == OP_LW || op_q == OP_SW) ? MEM : WB;
            MEM: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = alu_addr;
                state_d      = !bus.mem_ack ? MEM : (op_q == OP_LW) ? WB : run ? F_LO : IDLE;
            end
            WB: begin
                RegWrite = 1'b1;
                state_d  = run ? F_LO : IDLE;
            end
            default: state_d = HALT;
        endcase
    end
endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// tb_instr_fetch_sequencer: directed cycle-by-cycle checks of the fetch sequencer
module tb_instr_fetch_sequencer;
    logic        Fclk = 1'b0;
    logic        Rst_n, run, ack;
    logic [31:0] instr;
    logic [15:0] alu_addr, pc, w_pc;
    logic        IRWr0, IRWr1, MemWrite, MemtoReg, RegDst, RegWrite, halted, illegal;
    logic        w_IRWr0, w_IRWr1, w_MemWrite, w_MemtoReg, w_RegDst, w_RegWrite, w_halted, w_illegal;
    logic [9:0]  sig;
    int          checks = 0;
    int          errors = 0;
    instr_fetch_sequencer_if #(.AW(16)) m_if ();
    instr_fetch_sequencer_if #(.AW(16)) w_if ();
    assign m_if.mem_ack = ack;
    assign w_if.mem_ack = ack;
    instr_fetch_sequencer #(.AW(16), .RESET_PC(16'h0000)) dut (
        .Fclk(Fclk), .Rst_n(Rst_n), .run(run), .instr(instr), .alu_addr(alu_addr), .bus(m_if),
        .pc(pc), .IRWr0(IRWr0), .IRWr1(IRWr1), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .RegDst(RegDst), .RegWrite(RegWrite), .halted(halted), .illegal(illegal)
    );
    instr_fetch_sequencer #(.AW(16), .RESET_PC(16'hFFFE)) u_wrap (
        .Fclk(Fclk), .Rst_n(Rst_n), .run(run), .instr(instr), .alu_addr(alu_addr), .bus(w_if),
        .pc(w_pc), .IRWr0(w_IRWr0), .IRWr1(w_IRWr1), .MemWrite(w_MemWrite), .MemtoReg(w_MemtoReg),
        .RegDst(w_RegDst), .RegWrite(w_RegWrite), .halted(w_halted), .illegal(w_illegal)
    );
    assign sig = {m_if.mem_req, m_if.mem_we, IRWr0, IRWr1, MemWrite, MemtoReg, RegDst, RegWrite, halted, illegal};
    always #5 Fclk = ~Fclk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic cyc(input logic a);
        @(posedge Fclk);
        #2;
        ack = a;
        #1;
    endtask
    initial begin
        Rst_n = 1'b0; run = 1'b0; ack = 1'b0; instr = 32'h0000_0000; alu_addr = 16'h0000;
        #12;
        chk("rst_sig", sig, 10'h000);
        chk("rst_pc", pc, 16'h0000);
        chk("rst_wpc", w_pc, 16'hFFFE);
        Rst_n = 1'b1; run = 1'b1;
        instr = 32'h0022_1820;
        cyc(1); chk("r_flo", sig, 10'h280); chk("r_flo_addr", m_if.mem_addr, 16'h0000); chk("wrap_flo_addr", w_if.mem_addr, 16'hFFFE);
        cyc(1); chk("r_fhi", sig, 10'h240); chk("r_fhi_addr", m_if.mem_addr, 16'h0001); chk("wrap_fhi_addr", w_if.mem_addr, 16'hFFFF);
        cyc(0); chk("r_dec", sig, 10'h008); chk("r_pc", pc, 16'h0002); chk("wrap_pc", w_pc, 16'h0000);
        cyc(0); chk("r_exe", sig, 10'h008);
        cyc(0); chk("r_wb", sig, 10'h00C);
        cyc(0); chk("r_next_flo", sig, 10'h200); chk("r_next_addr", m_if.mem_addr, 16'h0002);
        instr = 32'h8C00_0000;
        cyc(1); chk("lw_flo", sig, 10'h280); chk("lw_flo_addr", m_if.mem_addr, 16'h0002);
        cyc(1); chk("lw_fhi", sig, 10'h240); chk("lw_fhi_addr", m_if.mem_addr, 16'h0003);
        cyc(0); chk("lw_dec", sig, 10'h010); chk("lw_pc", pc, 16'h0004);
        alu_addr = 16'h0040;
        cyc(0); chk("lw_exe", sig, 10'h010);
        run = 1'b0;
        cyc(0); chk("lw_mem_w1", sig, 10'h210); chk("lw_addr_w1", m_if.mem_addr, 16'h0040);
        cyc(0); chk("lw_mem_w2", sig, 10'h210); chk("lw_addr_w2", m_if.mem_addr, 16'h0040);
        cyc(1); chk("lw_mem_ack", sig, 10'h210); chk("lw_addr_ack", m_if.mem_addr, 16'h0040);
        cyc(0); chk("lw_wb", sig, 10'h014);
        cyc(0); chk("lw_idle1", sig, 10'h000);
        cyc(0); chk("lw_idle2", sig, 10'h000); chk("idle_pc", pc, 16'h0004);
        instr = 32'hAC00_0000; alu_addr = 16'h0050; run = 1'b1;
        cyc(1); chk("sw_flo", sig, 10'h280); chk("sw_flo_addr", m_if.mem_addr, 16'h0004);
        cyc(1); chk("sw_fhi", sig, 10'h240);
        cyc(0); chk("sw_dec", sig, 10'h000); chk("sw_pc", pc, 16'h0006);
        cyc(0); chk("sw_exe", sig, 10'h000);
        cyc(0); chk("sw_mem_w", sig, 10'h320); chk("sw_addr", m_if.mem_addr, 16'h0050);
        cyc(1); chk("sw_mem_ack", sig, 10'h320);
        cyc(0); chk("sw_next_flo", sig, 10'h200); chk("sw_next_addr", m_if.mem_addr, 16'h0006);
        instr = 32'hFC00_0000;
        cyc(1); chk("h_flo", sig, 10'h280);
        cyc(1); chk("h_fhi", sig, 10'h240);
        cyc(0); chk("h_dec", sig, 10'h000);
        cyc(1); chk("h_halt1", sig, 10'h002);
        cyc(1); chk("h_halt2", sig, 10'h002);
        Rst_n = 1'b0;
        cyc(0); chk("h_rst", sig, 10'h000);
        Rst_n = 1'b1;
        cyc(1); chk("ar_flo", sig, 10'h280);
        cyc(0); chk("ar_fhi_wait", sig, 10'h200); chk("ar_fhi_addr", m_if.mem_addr, 16'h0001);
        Rst_n = 1'b0;
        #1;
        chk("ar_async_sig", sig, 10'h000); chk("ar_async_pc", pc, 16'h0000);
        Rst_n = 1'b1;
        instr = 32'h5400_0000;
        cyc(1); chk("il_flo", sig, 10'h280);
        cyc(1); chk("il_fhi", sig, 10'h240);
        cyc(0); chk("il_dec", sig, 10'h000);
        cyc(1); chk("il_halt1", sig, 10'h003);
        cyc(1); chk("il_halt2", sig, 10'h003);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
